ikbd_serial_rx_fifo: RTL

IKBD_SERIAL_RX_FIFO -- requirements
Module: ikbd_serial_rx_fifo

---
 rtl/ikbd_serial_rx_fifo.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/ikbd_serial_rx_fifo.sv
// rtl/ikbd_serial_rx_fifo.sv - IKBD serial 8N1 receiver feeding a small byte FIFO
//
// Purpose: samples the MCU SCI transmit line (idle high, 8N1, LSB first) with a
// CLKS_PER_BIT oversampling counter and stores received bytes in a FIFO_DEPTH
// entry FIFO. Framing errors and overflows are reported as sticky flags.
//
// Ports:
//   CLKx2  - single clock, all state on posedge
//   RST    - asynchronous active-high reset
//   rxd    - serial input line
//   rd     - pop strobe, one entry per asserted cycle (ignored when empty)
//   dout   - FIFO head byte, meaningful while valid=1
//   valid  - FIFO not empty
//   count  - number of stored bytes
//   ferr   - sticky framing error
//   ovf    - sticky overflow
//   clr    - synchronous clear of ferr/ovf (a same-cycle set wins)
//
// Configuration: define IKBD_RX_SYNC_EN to add a 2-flop synchronizer on rxd
// (adds 2 cycles to all rxd-relative timing).

module ikbd_serial_rx_fifo #(
  parameter int CLKS_PER_BIT = 256,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                        CLKx2,
  input  logic                        RST,
  input  logic                        rxd,
  input  logic                        rd,
  output logic [7:0]                  dout,
  output logic                        valid,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic                        ferr,
  output logic                        ovf,
  input  logic                        clr
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAITHI} state_t;

  logic          rxd_s;
  logic          rxd_prev;
  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q;
  logic          shift_en, push, set_ferr;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count_q;
  logic          pop, push_ok, set_ovf;

`ifdef IKBD_RX_SYNC_EN
  logic [1:0] sync_q;
  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) sync_q <= 2'b11;
    else     sync_q <= {sync_q[0], rxd};
  end
  assign rxd_s = sync_q[1];
`else
  assign rxd_s = rxd;
`endif

  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      idx_q    <= '0;
      shift_q  <= '0;
      rxd_prev <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      rxd_prev <= rxd_s;
      if (shift_en) shift_q[idx_q] <= rxd_s;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q + CW'(1);
    idx_d    = idx_q;
    shift_en = 1'b0;
    push     = 1'b0;
    set_ferr = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (rxd_prev && !rxd_s) state_d = START;
      end
      START: begin
        // Re-check mid start bit so short low glitches are rejected.
        if (cnt_q == CNT_HALF) begin
          cnt_d = '0;
          if (rxd_s) begin
            state_d = IDLE;
          end else begin
            idx_d   = '0;
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d    = '0;
          shift_en = 1'b1;
          idx_d    = idx_q + 3'd1;
          if (idx_q == 3'd7) state_d = STOP;
        end
      end
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d = '0;
          if (rxd_s) begin
            push    = 1'b1;
            state_d = IDLE;
          end else begin
            set_ferr = 1'b1;
            state_d  = WAITHI;
          end
        end
      end
      WAITHI: begin
        // Hold off until the line is high again so a break is one error only.
        cnt_d = '0;
        if (rxd_s) state_d = IDLE;
      end
      default: begin
        cnt_d   = '0;
        state_d = IDLE;
      end
    endcase
  end

  assign pop     = rd && (count_q != '0);
  // A simultaneous pop frees a slot, so a push into a full FIFO still lands.
  assign push_ok = push && ((count_q != CNT_FULL) || pop);
  assign set_ovf = push && !push_ok;

  always_ff @(posedge CLKx2 or posedge RST) begin
    if (RST) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      ferr    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      if (push_ok) begin
        mem[wr_ptr] <= shift_q;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_q + (AW + 1)'(push_ok) - (AW + 1)'(pop);
      if (set_ferr)  ferr <= 1'b1;
      else if (clr)  ferr <= 1'b0;
      if (set_ovf)   ovf <= 1'b1;
      else if (clr)  ovf <= 1'b0;
    end
  end

  assign dout  = mem[rd_ptr];
  assign valid = (count_q != '0);
  assign count = count_q;

endmodule
